// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-side slave behind the round-robin arbiter.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  localparam int WORD_BYTES = 8;
  localparam int WORD_LSB   = 3;
  localparam logic [63:0] ERR_DATA_DEFAULT = 64'hDEAD_BEEF_DEAD_BEEF;
endpackage

// File: rtl/mem_ctrl_if.sv
// Arbiter <-> memory controller port: request bundle in, completion pulse and read data out.
interface mem_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic [ADDR_W-1:0] addr_m;
  logic [DATA_W-1:0] dout_m;
  logic              req_m;
  logic              wr_m;
  logic [DATA_W-1:0] din_m;
  logic              rdy_m;
  logic              busy;

  modport master (output addr_m, dout_m, req_m, wr_m, input din_m, rdy_m, busy);
  modport slave  (input addr_m, dout_m, req_m, wr_m, output din_m, rdy_m, busy);
endinterface

// File: rtl/mem_array.sv
// Single-port DEPTH x DATA_W RAM with synchronous write and a registered read.
// Latency: read data appears one cycle after re. Backpressure: none, always ready.
// Read register holds its value when re is low; contents themselves are never reset.
module mem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_ctrl.sv
// Memory slave for the arbiter: one request at a time from a word-addressed RAM.
// Latency: rdy_m LATENCY cycles after acceptance, then one GAP cycle before the next accept.
// Backpressure: req_m is only sampled in IDLE; the client holds it until rdy_m.
module mem_ctrl import mem_pkg::*; #(
  parameter int                DATA_W   = 64,
  parameter int                ADDR_W   = 64,
  parameter int                DEPTH    = 1024,
  parameter int                LATENCY  = 2,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input logic       clk,
  input logic       reset,
  mem_ctrl_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH);
  localparam bit         LAT1     = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              rdy_q;
  logic              busy_q;

  logic [ADDR_W-1:0] sel_addr;
  logic              rd_issue;
  logic              ram_re;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> WORD_LSB) < ADDR_W'(DEPTH);
  endfunction

  // The RAM read is launched one cycle ahead of RESP; with LATENCY=1 that is the accept cycle itself.
  always_comb begin
    sel_addr = (state == IDLE) ? bus.addr_m : addr_q;
    rd_issue = 1'b0;
    if (LAT1) rd_issue = (state == IDLE) && bus.req_m && !bus.wr_m;
    else      rd_issue = (state == WAIT) && (cnt == 4'd1) && !wr_q;
    ram_re   = rd_issue && in_range(sel_addr) && !reset;
    ram_we   = (state == RESP) && wr_q && in_range(addr_q) && !reset;
  end

  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (sel_addr[WORD_LSB +: AW]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (rd_issue) err_q <= !in_range(sel_addr);
      case (state)
        IDLE: begin
          if (bus.req_m) begin
            addr_q  <= bus.addr_m;
            wr_q    <= bus.wr_m;
            wdata_q <= bus.dout_m;
            cnt     <= CNT_LOAD;
            busy_q  <= 1'b1;
            if (LAT1) begin
              state <= RESP;
              rdy_q <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            rdy_q <= 1'b1;
          end
        end
        RESP: begin
          rdy_q <= 1'b0;
          state <= GAP;
        end
        GAP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // err_q and the RAM read register both hold between reads, so din_m holds too.
  assign bus.din_m = err_q ? ERR_DATA : ram_rdata;
  assign bus.rdy_m = rdy_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Drives LATENCY=2, 1 and 3 controllers and checks them against a word-array model of the memory.
module tb_mem_ctrl;
  localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // index 0: LATENCY=2, 1: LATENCY=1, 2: LATENCY=3
  int lat [3] = '{2, 1, 3};

  logic [63:0] addr_s [3];
  logic [63:0] dout_s [3];
  logic        req_s  [3];
  logic        wr_s   [3];
  logic [63:0] din_o  [3];
  logic        rdy_o  [3];
  logic        busy_o [3];

  mem_ctrl_if #(.DATA_W(64), .ADDR_W(64)) bus_l2 ();
  mem_ctrl_if #(.DATA_W(64), .ADDR_W(64)) bus_l1 ();
  mem_ctrl_if #(.DATA_W(64), .ADDR_W(64)) bus_l3 ();

  assign bus_l2.addr_m = addr_s[0];
  assign bus_l2.dout_m = dout_s[0];
  assign bus_l2.req_m  = req_s[0];
  assign bus_l2.wr_m   = wr_s[0];
  assign din_o[0]      = bus_l2.din_m;
  assign rdy_o[0]      = bus_l2.rdy_m;
  assign busy_o[0]     = bus_l2.busy;

  assign bus_l1.addr_m = addr_s[1];
  assign bus_l1.dout_m = dout_s[1];
  assign bus_l1.req_m  = req_s[1];
  assign bus_l1.wr_m   = wr_s[1];
  assign din_o[1]      = bus_l1.din_m;
  assign rdy_o[1]      = bus_l1.rdy_m;
  assign busy_o[1]     = bus_l1.busy;

  assign bus_l3.addr_m = addr_s[2];
  assign bus_l3.dout_m = dout_s[2];
  assign bus_l3.req_m  = req_s[2];
  assign bus_l3.wr_m   = wr_s[2];
  assign din_o[2]      = bus_l3.din_m;
  assign rdy_o[2]      = bus_l3.rdy_m;
  assign busy_o[2]     = bus_l3.busy;

  mem_ctrl #(.LATENCY(2)) dut_l2 (.clk(clk), .reset(reset), .bus(bus_l2));
  mem_ctrl #(.LATENCY(1)) dut_l1 (.clk(clk), .reset(reset), .bus(bus_l1));
  mem_ctrl #(.LATENCY(3)) dut_l3 (.clk(clk), .reset(reset), .bus(bus_l3));

  // Reference: per-controller word store for the first NW words, plus the last value din_m showed.
  logic [63:0] mdl      [3][NW];
  bit          vld      [3][NW];
  logic [63:0] last_din [3];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One client transaction: request held until rdy_m; chg swaps addr_m to alt after acceptance.
  task automatic txn(input int d, input bit wr, input logic [63:0] addr, input logic [63:0] data,
                     input bit chg, input logic [63:0] alt, input string tag);
    logic [63:0] word;
    logic [63:0] exp;
    bit          inr;
    word = addr >> 3;
    inr  = (word < 64'd1024);
    @(negedge clk);
    req_s[d] = 1'b1; wr_s[d] = wr; addr_s[d] = addr; dout_s[d] = data;
    for (int k = 1; k <= lat[d]; k++) begin
      @(negedge clk);
      if (k == 1 && chg) addr_s[d] = alt;
      if (k < lat[d]) check({tag, " early rdy"}, 64'(rdy_o[d]), 64'd0);
    end
    check({tag, " rdy"}, 64'(rdy_o[d]), 64'd1);
    if (wr) begin
      if (inr) begin
        mdl[d][int'(word)] = data;
        vld[d][int'(word)] = 1'b1;
      end
      check({tag, " din hold"}, din_o[d], last_din[d]);
    end else begin
      exp = inr ? mdl[d][int'(word)] : ERR;
      check({tag, " rdata"}, din_o[d], exp);
      last_din[d] = exp;
    end
    req_s[d] = 1'b0;
    @(negedge clk);
    check({tag, " gap rdy"}, 64'(rdy_o[d]), 64'd0);
    check({tag, " gap busy"}, 64'(busy_o[d]), 64'd1);
    @(negedge clk);
    check({tag, " idle busy"}, 64'(busy_o[d]), 64'd0);
  endtask

  initial begin
    int          cur;
    int          last;
    int          pulses;
    bit          wr;
    logic [63:0] a;
    logic [63:0] dat;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr_s[i] = '0; dout_s[i] = '0; req_s[i] = 1'b0; wr_s[i] = 1'b0; last_din[i] = '0;
      for (int w = 0; w < NW; w++) vld[i][w] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle rdy", 64'(rdy_o[0]), 64'd0);
      check("idle busy", 64'(busy_o[0]), 64'd0);
      check("idle din", din_o[0], 64'd0);
    end

    // Basic write then read-back
    txn(0, 1'b1, 64'h10, 64'h1122334455667788, 1'b0, 64'd0, "wr10");
    txn(0, 1'b0, 64'h10, 64'd0, 1'b0, 64'd0, "rd10");
    check("rd10 literal", din_o[0], 64'h1122334455667788);

    for (int w = 0; w < NW; w++)
      if (w != 2) txn(0, 1'b1, 64'(w * 8), {$urandom, $urandom}, 1'b0, 64'd0, "preload");

    // Continuous request, alternating 0x0 / 0x8
    @(negedge clk);
    cur = 0; last = -1; pulses = 0;
    req_s[0] = 1'b1; wr_s[0] = 1'b0; addr_s[0] = 64'h0;
    for (int c = 0; c < 40 && pulses < 6; c++) begin
      @(negedge clk);
      if (rdy_o[0]) begin
        check("stream rdata", din_o[0], mdl[0][cur]);
        last_din[0] = mdl[0][cur];
        if (last >= 0) check("stream period", 64'(c - last), 64'd4);
        last = c; pulses++;
        cur = 1 - cur;
        addr_s[0] = 64'(cur * 8);
      end
    end
    req_s[0] = 1'b0;
    check("stream pulses", 64'(pulses), 64'd6);
    repeat (2) @(negedge clk);

    // Out-of-range accesses
    txn(0, 1'b0, 64'h2000, 64'd0, 1'b0, 64'd0, "rd oor");
    txn(0, 1'b1, 64'h2000, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0, 64'd0, "wr oor");
    txn(0, 1'b0, 64'h0, 64'd0, 1'b0, 64'd0, "rd0 after oor");

    // Reset during WAIT aborts a write to 0x18
    @(negedge clk);
    req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 64'h18; dout_s[0] = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    req_s[0] = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) last_din[i] = '0;
    check("abort busy", 64'(busy_o[0]), 64'd0);
    check("abort din", din_o[0], 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort rdy", 64'(rdy_o[0]), 64'd0);
    end
    txn(0, 1'b0, 64'h18, 64'd0, 1'b0, 64'd0, "rd18 after abort");

    // Random traffic on the LATENCY=2 controller
    for (int n = 0; n < 30; n++) begin
      wr  = 1'($urandom);
      dat = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) a = 64'((1024 + $urandom_range(0, 5000)) * 8 + $urandom_range(0, 7));
      else                           a = 64'($urandom_range(0, NW - 1) * 8 + $urandom_range(0, 7));
      if (!wr && (a >> 3) < NW && !vld[0][int'(a >> 3)]) wr = 1'b1;
      txn(0, wr, a, dat, 1'b0, 64'd0, "rand");
    end

    // LATENCY=1: unaligned addresses hit the same word
    txn(1, 1'b1, 64'h8, 64'hA5A5_5A5A_0102_0304, 1'b0, 64'd0, "l1 wr8");
    txn(1, 1'b0, 64'h8, 64'd0, 1'b0, 64'd0, "l1 rd8");
    txn(1, 1'b0, 64'hF, 64'd0, 1'b0, 64'd0, "l1 rdF");
    txn(1, 1'b0, 64'h4000, 64'd0, 1'b0, 64'd0, "l1 rd oor");

    // LATENCY=3: address changes after acceptance are ignored
    txn(2, 1'b1, 64'h20, 64'h0000_AAAA_0000_AAAA, 1'b0, 64'd0, "l3 wr20");
    txn(2, 1'b1, 64'h28, 64'h0000_BBBB_0000_BBBB, 1'b0, 64'd0, "l3 wr28");
    txn(2, 1'b0, 64'h20, 64'd0, 1'b1, 64'h28, "l3 rd20 chg");
    txn(2, 1'b1, 64'h30, 64'h0000_CCCC_0000_CCCC, 1'b1, 64'h20, "l3 wr30 chg");
    txn(2, 1'b0, 64'h30, 64'd0, 1'b0, 64'd0, "l3 rd30");
    txn(2, 1'b0, 64'h20, 64'd0, 1'b0, 64'd0, "l3 rd20");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
